// File: rtl/core_sequencer_if.sv
// Control/status bundle between the core sequencer and the rest of the RiscyD2 core.
// The master side is the sequencer itself; the slave side is decode/execute/mmio.
interface core_sequencer_if;
    logic        run_i;
    logic        step_i;
    logic        illegal_i;
    logic        is_mem_i;
    logic        ex_busy_i;
    logic        mem_ready_i;
    logic        branch_taken_i;
    logic [31:0] target_i;
    logic [2:0]  state_o;
    logic [31:0] pc_o;
    logic        mem_req_o;
    logic        wb_en_o;
    logic        retired_o;
    logic [31:0] instret_o;
    logic        trap_o;
    logic [31:0] mepc_o;
    logic        halted_o;
    logic        timeout_o;

    modport master (
        input  run_i, step_i, illegal_i, is_mem_i, ex_busy_i, mem_ready_i,
               branch_taken_i, target_i,
        output state_o, pc_o, mem_req_o, wb_en_o, retired_o, instret_o,
               trap_o, mepc_o, halted_o, timeout_o
    );

    modport slave (
        output run_i, step_i, illegal_i, is_mem_i, ex_busy_i, mem_ready_i,
               branch_taken_i, target_i,
        input  state_o, pc_o, mem_req_o, wb_en_o, retired_o, instret_o,
               trap_o, mepc_o, halted_o, timeout_o
    );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer: drives the shared phase bus, owns the PC, handles
// memory wait-states, execute stalls, traps, debug run/halt/step and instret.
module core_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC      = 32'h0000_0100,
    parameter int unsigned STALL_TIMEOUT = 255
) (
    input  logic               clk_i,
    input  logic               rst_i,
    core_sequencer_if.master   bus
);
    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_RF    = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_WB    = 3'd4,
        ST_HALT  = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] instret_q, instret_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic        timeout_q, timeout_d;
    logic        step_active_q, step_active_d;
    logic        trap_pend_q, trap_pend_d;

    logic        in_wb_s;
    logic        wb_trap_s;
    logic [31:0] wait_next_s;

    assign in_wb_s     = (state_q == ST_WB);
    assign wb_trap_s   = trap_pend_q | (bus.branch_taken_i & (bus.target_i[1:0] != 2'b00));
    assign wait_next_s = wait_cnt_q + 32'd1;

    // Next-state, PC, trap and counter update logic
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        mepc_d        = mepc_q;
        instret_d     = instret_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_d     = timeout_q;
        step_active_d = step_active_q;
        trap_pend_d   = trap_pend_q;
        case (state_q)
            ST_HALT: begin
                // A stall timeout parks the core here until reset
                if (timeout_q) begin
                    state_d = ST_HALT;
                end else if (bus.run_i) begin
                    state_d       = ST_FETCH;
                    step_active_d = 1'b0;
                end else if (bus.step_i) begin
                    state_d       = ST_FETCH;
                    step_active_d = 1'b1;
                end else begin
                    state_d = ST_HALT;
                end
            end
            ST_FETCH: begin
                state_d = ST_RF;
            end
            ST_RF: begin
                if (bus.illegal_i) begin
                    trap_pend_d = 1'b1;
                    state_d     = ST_WB;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (bus.ex_busy_i) begin
                    state_d = ST_EXEC;
                end else if (bus.is_mem_i) begin
                    state_d    = ST_MEM;
                    wait_cnt_d = 32'd0;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                // Ready on the limit cycle still completes the access
                if (bus.mem_ready_i) begin
                    state_d = ST_WB;
                end else if ((STALL_TIMEOUT != 32'd0) && (wait_next_s == STALL_TIMEOUT)) begin
                    wait_cnt_d = wait_next_s;
                    timeout_d  = 1'b1;
                    state_d    = ST_HALT;
                end else begin
                    wait_cnt_d = wait_next_s;
                    state_d    = ST_MEM;
                end
            end
            ST_WB: begin
                trap_pend_d = 1'b0;
                if (wb_trap_s) begin
                    pc_d   = TRAP_VEC;
                    mepc_d = pc_q;
                end else begin
                    pc_d      = bus.branch_taken_i ? bus.target_i : (pc_q + 32'd4);
                    instret_d = instret_q + 32'd1;
                end
                if (step_active_q || !bus.run_i) begin
                    state_d       = ST_HALT;
                    step_active_d = 1'b0;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // State and architectural register update with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_HALT;
            pc_q          <= RESET_PC;
            mepc_q        <= 32'd0;
            instret_q     <= 32'd0;
            wait_cnt_q    <= 32'd0;
            timeout_q     <= 1'b0;
            step_active_q <= 1'b0;
            trap_pend_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            mepc_q        <= mepc_d;
            instret_q     <= instret_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_q     <= timeout_d;
            step_active_q <= step_active_d;
            trap_pend_q   <= trap_pend_d;
        end
    end

    assign bus.state_o   = state_q;
    assign bus.pc_o      = pc_q;
    assign bus.mepc_o    = mepc_q;
    assign bus.instret_o = instret_q;
    assign bus.timeout_o = timeout_q;
    assign bus.halted_o  = (state_q == ST_HALT);
    assign bus.mem_req_o = (state_q == ST_MEM);
    // Commit and trap strobes are the only outputs that see WB-time branch inputs
    assign bus.wb_en_o   = in_wb_s & ~wb_trap_s;
    assign bus.retired_o = in_wb_s & ~wb_trap_s;
    assign bus.trap_o    = in_wb_s & wb_trap_s;
endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: each instruction pushes its expected outcome,
// which is popped and compared when the DUT reaches WB.
module tb_core_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    core_sequencer_if sif();

    core_sequencer #(
        .RESET_PC      (32'h0000_0000),
        .TRAP_VEC      (32'h0000_0100),
        .STALL_TIMEOUT (4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (sif)
    );

    typedef struct {
        bit          trap;
        logic [31:0] pc;
        logic [31:0] mepc;
        logic [31:0] instret;
        int          cycles;
        int          mreq;
        logic [2:0]  post;
    } exp_t;

    exp_t        sb[$];
    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] m_pc, m_mepc, m_instret;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        sif.step_i         = 1'b0;
        sif.illegal_i      = 1'b0;
        sif.is_mem_i       = 1'b0;
        sif.ex_busy_i      = 1'b0;
        sif.mem_ready_i    = 1'b0;
        sif.branch_taken_i = 1'b0;
        sif.target_i       = 32'd0;
    endtask

    // Push the expectation, then answer the DUT phase by phase until it leaves WB
    task automatic do_instr(input bit ill, input bit mem, input int busy_n, input int rdy_n,
                            input bit br, input logic [31:0] tgt, input bit stp, input bit extra);
        exp_t e, g;
        int   cyc = 0, busy_cnt = 0, mem_cnt = 0, mreq = 0;
        bit   stepped = 1'b0, extra_done = 1'b0, done = 1'b0;
        e.trap = ill || (br && (tgt[1:0] != 2'b00));
        if (e.trap) begin
            m_mepc = m_pc;
            m_pc   = 32'h0000_0100;
        end else begin
            m_pc      = br ? tgt : (m_pc + 32'd4);
            m_instret = m_instret + 32'd1;
        end
        e.pc      = m_pc;
        e.mepc    = m_mepc;
        e.instret = m_instret;
        e.cycles  = ill ? 3 : (4 + busy_n + (mem ? rdy_n : 0));
        e.mreq    = (!ill && mem) ? rdy_n : 0;
        e.post    = sif.run_i ? 3'd0 : 3'd5;
        sb.push_back(e);
        for (int k = 0; k < 64 && !done; k++) begin
            clear_inputs();
            sif.is_mem_i = mem;
            if (cyc > 0 || sif.state_o == 3'd0) cyc++;
            case (sif.state_o)
                3'd5: if (stp && !stepped) begin sif.step_i = 1'b1; stepped = 1'b1; end
                3'd1: sif.illegal_i = ill;
                3'd2: begin
                    if (extra && !extra_done) begin sif.step_i = 1'b1; extra_done = 1'b1; end
                    if (busy_cnt < busy_n) begin sif.ex_busy_i = 1'b1; busy_cnt++; end
                end
                3'd3: begin
                    mem_cnt++;
                    if (sif.mem_req_o) mreq++;
                    sif.mem_ready_i = (mem_cnt == rdy_n);
                end
                3'd4: begin
                    sif.branch_taken_i = br;
                    sif.target_i       = tgt;
                    #1;
                    g = sb.pop_front();
                    check_val("wb_en",   {31'd0, sif.wb_en_o},   {31'd0, !g.trap});
                    check_val("retired", {31'd0, sif.retired_o}, {31'd0, !g.trap});
                    check_val("trap",    {31'd0, sif.trap_o},    {31'd0, g.trap});
                    check_val("latency", cyc,  g.cycles);
                    check_val("mem_req_cycles", mreq, g.mreq);
                    tick();
                    check_val("pc",      sif.pc_o,      g.pc);
                    check_val("mepc",    sif.mepc_o,    g.mepc);
                    check_val("instret", sif.instret_o, g.instret);
                    check_val("post_state", {29'd0, sif.state_o}, {29'd0, g.post});
                    done = 1'b1;
                end
                default: ;
            endcase
            if (!done) tick();
        end
        if (!done) check_val("wb_reached", 32'd0, 32'd1);
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int mem_cycles;
        logic [31:0] pc_before;
        m_pc = 32'd0; m_mepc = 32'd0; m_instret = 32'd0;
        clear_inputs();
        sif.run_i = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        check_val("rst_state",   {29'd0, sif.state_o}, 32'd5);
        check_val("rst_pc",      sif.pc_o, 32'd0);
        check_val("rst_mepc",    sif.mepc_o, 32'd0);
        check_val("rst_instret", sif.instret_o, 32'd0);
        check_val("rst_flags", {26'd0, sif.timeout_o, sif.halted_o, sif.mem_req_o,
                                sif.wb_en_o, sif.retired_o, sif.trap_o}, 32'h10);
        rst = 1'b0;
        tick();
        check_val("first_fetch", {29'd0, sif.state_o}, 32'd0);

        // Straight-line ALU, load, multi-cycle execute
        for (int i = 0; i < 3; i++) do_instr(1'b0, 1'b0, 0, 0, 1'b0, 32'd0, 1'b0, 1'b0);
        do_instr(1'b0, 1'b1, 0, 3, 1'b0, 32'd0, 1'b0, 1'b0);
        do_instr(1'b0, 1'b0, 2, 0, 1'b0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) do_instr(1'b0, 1'b0, 0, 0, 1'b0, 32'd0, 1'b0, 1'b0);
        // Illegal at 0x20, then branches: aligned, misaligned, aligned
        do_instr(1'b1, 1'b0, 0, 0, 1'b0, 32'd0, 1'b0, 1'b0);
        do_instr(1'b0, 1'b0, 0, 0, 1'b1, 32'h10, 1'b0, 1'b0);
        do_instr(1'b0, 1'b0, 0, 0, 1'b1, 32'h42, 1'b0, 1'b0);
        do_instr(1'b0, 1'b0, 0, 0, 1'b1, 32'h40, 1'b0, 1'b0);
        // Ready on the very cycle the stall limit is reached
        do_instr(1'b0, 1'b1, 0, 4, 1'b0, 32'd0, 1'b0, 1'b0);
        // Drop run mid-instruction: completes, then halts
        sif.run_i = 1'b0;
        do_instr(1'b0, 1'b0, 1, 0, 1'b0, 32'd0, 1'b0, 1'b0);
        // Two single steps, with a stray step pulse during EXEC
        do_instr(1'b0, 1'b0, 0, 0, 1'b0, 32'd0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        check_val("step_idle_state", {29'd0, sif.state_o}, 32'd5);
        check_val("step_idle_instret", sif.instret_o, m_instret);
        do_instr(1'b0, 1'b1, 0, 1, 1'b0, 32'd0, 1'b1, 1'b0);
        check_val("halted_o", {31'd0, sif.halted_o}, 32'd1);
        // Run and step together: run wins, no halt after WB
        sif.run_i = 1'b1;
        do_instr(1'b0, 1'b0, 0, 0, 1'b0, 32'd0, 1'b1, 1'b0);

        // Store whose ready never comes
        pc_before  = m_pc;
        mem_cycles = 0;
        for (int k = 0; k < 20 && sif.state_o != 3'd5; k++) begin
            sif.is_mem_i    = 1'b1;
            sif.mem_ready_i = 1'b0;
            if (sif.mem_req_o) mem_cycles++;
            tick();
        end
        check_val("to_mem_cycles", mem_cycles, 32'd4);
        check_val("to_state",   {29'd0, sif.state_o}, 32'd5);
        check_val("to_flag",    {31'd0, sif.timeout_o}, 32'd1);
        check_val("to_pc",      sif.pc_o, pc_before);
        check_val("to_instret", sif.instret_o, m_instret);
        clear_inputs();
        for (int i = 0; i < 3; i++) tick();
        check_val("to_stuck", {29'd0, sif.state_o}, 32'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("to_rst_flag", {31'd0, sif.timeout_o}, 32'd0);
        check_val("to_rst_pc", sif.pc_o, 32'd0);
        tick();
        check_val("to_rst_fetch", {29'd0, sif.state_o}, 32'd0);
        check_val("sb_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
